// File: rtl/bmc_pkg.sv
// Shared types and default sizing for the factoring-checker labs.
package bmc_pkg;

  // Accumulator direction, sampled with each accepted operand pair.
  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int DEF_W     = 64;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/factor_table.sv
// DEPTH x 2W target register file: one write port, one combinational read port.
// Kept in flops (not block RAM) because it needs a synchronous clear and an
// asynchronous read driven by the current walk index.
module factor_table
  import bmc_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [2*W-1:0]  wdata,
  input  logic [IW-1:0]   raddr,
  output logic [2*W-1:0]  rdata
);

  logic [2*W-1:0] entry_q [DEPTH];
  logic [2*W-1:0] entry_d [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Load the entry when the write strobe addresses it, otherwise hold.
      always_comb begin
        entry_d[gi] = entry_q[gi];
        if (we && (waddr == IW'(gi))) begin
          entry_d[gi] = wdata;
        end
      end

      // Entry register; a cleared entry is zero, which can never match.
      always_ff @(posedge clk) begin
        if (!rst) begin
          entry_q[gi] <= '0;
        end else begin
          entry_q[gi] <= entry_d[gi];
        end
      end
    end
  endgenerate

  assign rdata = entry_q[raddr];

endmodule

// File: rtl/factor_table_checker.sv
// Walks a loadable table of 2W-bit targets, checks each accepted (x,y) as a
// nontrivial factor pair of the current entry, records sticky per-entry hits
// and runs an add/subtract accumulator carrying the algebraic identity check.
module factor_table_checker
  import bmc_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x,
  input  logic [W-1:0]      y,
  input  logic              mode,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_addr,
  input  logic [2*W-1:0]    cfg_data,
  input  logic              clr_hits,
  output logic [IW-1:0]     idx,
  output logic [W-1:0]      acc,
  output logic              hit_valid,
  output logic [IW-1:0]     hit_idx,
  output logic [W-1:0]      hit_x,
  output logic [W-1:0]      hit_y,
  output logic [DEPTH-1:0]  hit_mask,
  output logic              all_hit
);

  logic [IW-1:0]    idx_q, idx_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             hit_valid_q, hit_valid_d;
  logic [IW-1:0]    hit_idx_q, hit_idx_d;
  logic [W-1:0]     hit_x_q, hit_x_d;
  logic [W-1:0]     hit_y_q, hit_y_d;
  logic [DEPTH-1:0] hit_mask_q, hit_mask_d;

  logic             accept;
  logic             match;
  logic [2*W-1:0]   target;
  logic [2*W-1:0]   product;

  // Config writes own the cycle, so operands are refused while one is active.
  assign in_ready = rst & ~cfg_we;
  assign accept   = in_valid & in_ready;

  factor_table #(
    .W     (W),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_q),
    .rdata (target)
  );

  // Full 2W-bit product: operands are zero-extended before multiplying.
  assign product = {{W{1'b0}}, x} * {{W{1'b0}}, y};

  // Trivial factors (0 and 1) are excluded, so zeroed entries stay inert.
  assign match = accept && (x > W'(1)) && (y > W'(1)) && (product == target);

  // Index walk and accumulator advance only on an accepted pair.
  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (accept) begin
      idx_d = idx_q + IW'(1);
      if (mode_e'(mode) == MODE_SUB) begin
        acc_d = acc_q - x;
      end else begin
        acc_d = acc_q + x;
      end
    end
  end

  // Hit capture and sticky mask; a same-cycle match overrides both clears.
  always_comb begin
    hit_valid_d = match;
    hit_idx_d   = hit_idx_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    hit_mask_d  = hit_mask_q;
    if (clr_hits) begin
      hit_mask_d = '0;
    end
    if (cfg_we) begin
      hit_mask_d[cfg_addr] = 1'b0;
    end
    if (match) begin
      hit_idx_d          = idx_q;
      hit_x_d            = x;
      hit_y_d            = y;
      hit_mask_d[idx_q]  = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q       <= '0;
      acc_q       <= W'(1);
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
      hit_x_q     <= '0;
      hit_y_q     <= '0;
      hit_mask_q  <= '0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      hit_mask_q  <= hit_mask_d;
    end
  end

  assign idx       = idx_q;
  assign acc       = acc_q;
  assign hit_valid = hit_valid_q;
  assign hit_idx   = hit_idx_q;
  assign hit_x     = hit_x_q;
  assign hit_y     = hit_y_q;
  assign hit_mask  = hit_mask_q;
  assign all_hit   = &hit_mask_q;

`ifdef FORMAL
  logic [W-1:0] ident_lhs;
  logic [W-1:0] ident_rhs;

  assign ident_lhs = (acc_q - x) * (acc_q + x);
  assign ident_rhs = (acc_q * acc_q) - (x * x);

  // Identity, hit consistency and all_hit reduction checked every cycle out of reset.
  always @(posedge clk) begin
    if (rst) begin
      a_identity : assert (ident_lhs == ident_rhs);
      a_hit_mask : assert (!hit_valid_q || hit_mask_q[hit_idx_q]);
      a_all_hit  : assert (all_hit == &hit_mask_q);
      c_all_hit  : cover (all_hit);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cover
      // Reachability of a factor hit on each individual entry.
      always @(posedge clk) begin
        c_match : cover (rst && match && (idx_q == IW'(gi)));
      end
    end
  endgenerate
`endif

endmodule
